// File: rtl/multi_register_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_register_bank                                                        |
// | Bank of NREG WIDTH-bit registers with load/inc/dec/shift/clear, one bus    |
// | read port, registered carry flag and a zero flag.                          |
// | Optional build macro: REG_TRISTATE_EN (Q floats when OE_n is high).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_register_bank #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             G_n,
  input  logic [AW-1:0]    WSEL,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  input  logic [AW-1:0]    RSEL,
  input  logic             OE_n,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  localparam logic [2:0] c_op_load = 3'b001;
  localparam logic [2:0] c_op_inc  = 3'b010;
  localparam logic [2:0] c_op_dec  = 3'b011;
  localparam logic [2:0] c_op_shl  = 3'b100;
  localparam logic [2:0] c_op_shr  = 3'b101;
  localparam logic [2:0] c_op_clr  = 3'b110;

  logic [WIDTH-1:0] w_regs [NREG];
  logic [WIDTH-1:0] w_wr_cur;
  logic [WIDTH-1:0] w_wr_nxt;
  logic [WIDTH-1:0] w_rd_val;
  logic             w_wsel_ok;
  logic             w_apply;
  logic             w_co_nxt;
  logic             r_co;

  // Out-of-range selects fall through the mux and read as zero.
  always_comb begin
    w_wr_cur = '0;
    w_rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (WSEL == AW'(i)) w_wr_cur = w_regs[i];
      if (RSEL == AW'(i)) w_rd_val = w_regs[i];
    end
  end

  assign w_wsel_ok = ({1'b0, WSEL} < (AW+1)'(NREG));
  assign w_apply   = ~G_n & w_wsel_ok;

  always_comb begin
    w_wr_nxt = w_wr_cur;
    w_co_nxt = r_co;
    case (OP)
      c_op_load: begin
        w_wr_nxt = D;
        w_co_nxt = 1'b0;
      end
      c_op_inc: begin
        w_wr_nxt = w_wr_cur + WIDTH'(1);
        w_co_nxt = &w_wr_cur;
      end
      c_op_dec: begin
        w_wr_nxt = w_wr_cur - WIDTH'(1);
        w_co_nxt = ~|w_wr_cur;
      end
      c_op_shl: begin
        w_wr_nxt = {w_wr_cur[WIDTH-2:0], SI};
        w_co_nxt = w_wr_cur[WIDTH-1];
      end
      c_op_shr: begin
        w_wr_nxt = {SI, w_wr_cur[WIDTH-1:1]};
        w_co_nxt = w_wr_cur[0];
      end
      c_op_clr: begin
        w_wr_nxt = '0;
        w_co_nxt = 1'b0;
      end
      default: begin
        w_wr_nxt = w_wr_cur;
        w_co_nxt = r_co;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] r_val;
      always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
          r_val <= '0;
        end else if (w_apply && (WSEL == AW'(gi))) begin
          r_val <= w_wr_nxt;
        end
      end
      assign w_regs[gi] = r_val;
    end
  endgenerate

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_co <= 1'b0;
    end else if (w_apply) begin
      r_co <= w_co_nxt;
    end
  end

  assign CO   = r_co;
  assign ZERO = ~|w_rd_val;

`ifdef REG_TRISTATE_EN
  assign Q = OE_n ? {WIDTH{1'bz}} : w_rd_val;
`else
  assign Q = OE_n ? '0 : w_rd_val;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_register_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_register_bank                                                     |
// | Scoreboard bench for a 4-register bank and a 3-register bank in parallel.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_register_bank;

  typedef struct {
    logic [7:0] q;
    logic       co;
    logic       z;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b0;
  logic       G_n = 1'b1;
  logic [1:0] WSEL = '0;
  logic [2:0] OP = '0;
  logic [7:0] D = '0;
  logic       SI = 1'b0;
  logic [1:0] RSEL = '0;
  logic       OE_n = 1'b0;
  logic [7:0] Q, Q3;
  logic       CO, CO3, ZERO, ZERO3;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic [7:0] m [2][4];
  logic       mco [2];
  int         nr [2] = '{4, 3};

  multi_register_bank #(.WIDTH(8), .NREG(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .G_n(G_n), .WSEL(WSEL), .OP(OP), .D(D),
    .SI(SI), .RSEL(RSEL), .OE_n(OE_n), .Q(Q), .CO(CO), .ZERO(ZERO)
  );

  multi_register_bank #(.WIDTH(8), .NREG(3)) dut3 (
    .CLK(CLK), .CLR_n(CLR_n), .G_n(G_n), .WSEL(WSEL), .OP(OP), .D(D),
    .SI(SI), .RSEL(RSEL), .OE_n(OE_n), .Q(Q3), .CO(CO3), .ZERO(ZERO3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic exp_t expect_of(input int b);
    exp_t e;
    logic [7:0] rd;
    rd   = (int'(RSEL) < nr[b]) ? m[b][RSEL] : 8'h00;
    e.z  = (rd == 8'h00);
    e.co = mco[b];
`ifdef REG_TRISTATE_EN
    e.q  = OE_n ? 8'hzz : rd;
`else
    e.q  = OE_n ? 8'h00 : rd;
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      mco[b] = 1'b0;
      for (int r = 0; r < 4; r++) m[b][r] = 8'h00;
    end
  endtask

  task automatic model_step(input logic [1:0] w, input logic [2:0] op,
                            input logic [7:0] d, input logic si, input logic gn);
    logic [7:0] r;
    for (int b = 0; b < 2; b++) begin
      if (!gn && int'(w) < nr[b]) begin
        r = m[b][w];
        case (op)
          3'd1: begin m[b][w] = d;               mco[b] = 1'b0;       end
          3'd2: begin m[b][w] = r + 8'd1;        mco[b] = (r == 8'hFF); end
          3'd3: begin m[b][w] = r - 8'd1;        mco[b] = (r == 8'h00); end
          3'd4: begin m[b][w] = {r[6:0], si};    mco[b] = r[7];       end
          3'd5: begin m[b][w] = {si, r[7:1]};    mco[b] = r[0];       end
          3'd6: begin m[b][w] = 8'h00;           mco[b] = 1'b0;       end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cmp_outputs(input string tag, input exp_t e4, input exp_t e3);
    chk({tag, ".q4"}, 32'(Q), 32'(e4.q));
    chk({tag, ".co4"}, 32'(CO), 32'(e4.co));
    chk({tag, ".z4"}, 32'(ZERO), 32'(e4.z));
    chk({tag, ".q3"}, 32'(Q3), 32'(e3.q));
    chk({tag, ".co3"}, 32'(CO3), 32'(e3.co));
    chk({tag, ".z3"}, 32'(ZERO3), 32'(e3.z));
  endtask

  task automatic do_op(input string tag, input logic [1:0] w, input logic [2:0] op,
                       input logic [7:0] d, input logic si, input logic gn);
    exp_t e4, e3;
    @(negedge CLK);
    WSEL = w; OP = op; D = d; SI = si; G_n = gn;
    model_step(w, op, d, si, gn);
    sb.push_back(expect_of(0));
    sb.push_back(expect_of(1));
    @(posedge CLK);
    #1;
    if (sb.size() < 2) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd2);
    end else begin
      e4 = sb.pop_front();
      e3 = sb.pop_front();
      cmp_outputs(tag, e4, e3);
    end
  endtask

  task automatic set_read(input string tag, input logic [1:0] rs, input logic oe);
    @(negedge CLK);
    G_n = 1'b1; RSEL = rs; OE_n = oe;
    #1;
    cmp_outputs(tag, expect_of(0), expect_of(1));
  endtask

  initial begin
    model_reset();
    #3;
    cmp_outputs("reset", expect_of(0), expect_of(1));
    @(negedge CLK);
    CLR_n = 1'b1;

    for (int r = 0; r < 4; r++) do_op("fill_a5", 2'(r), 3'd1, 8'hA5, 1'b0, 1'b0);
    set_read("pre_rst", 2'd1, 1'b0);
    do_op("co_set", 2'd1, 3'd4, 8'h00, 1'b0, 1'b0);
    #2;
    CLR_n = 1'b0;
    model_reset();
    #1;
    cmp_outputs("async_rst", expect_of(0), expect_of(1));
    @(negedge CLK);
    CLR_n = 1'b1;

    for (int r = 0; r < 4; r++) do_op("fill_ab", 2'(r), 3'd1, 8'h10 + 8'(r), 1'b0, 1'b0);
    set_read("rd2_pre", 2'd2, 1'b0);
    do_op("load2", 2'd2, 3'd1, 8'h3C, 1'b0, 1'b0);
    set_read("rd1_keep", 2'd1, 1'b0);
    set_read("rd3_keep", 2'd3, 1'b0);

    set_read("sel0", 2'd0, 1'b0);
    do_op("ld_ff", 2'd0, 3'd1, 8'hFF, 1'b0, 1'b0);
    do_op("inc_wrap", 2'd0, 3'd2, 8'h00, 1'b0, 1'b0);
    do_op("inc_1", 2'd0, 3'd2, 8'h00, 1'b0, 1'b0);
    do_op("ld_00", 2'd0, 3'd1, 8'h00, 1'b0, 1'b0);
    do_op("dec_wrap", 2'd0, 3'd3, 8'h00, 1'b0, 1'b0);

    set_read("sel1", 2'd1, 1'b0);
    do_op("ld_81", 2'd1, 3'd1, 8'h81, 1'b0, 1'b0);
    do_op("shl", 2'd1, 3'd4, 8'h00, 1'b0, 1'b0);
    do_op("shr", 2'd1, 3'd5, 8'h00, 1'b1, 1'b0);
    do_op("clear", 2'd1, 3'd6, 8'h00, 1'b0, 1'b0);

    do_op("ld_ff2", 2'd0, 3'd1, 8'hFF, 1'b0, 1'b0);
    do_op("co_one", 2'd0, 3'd2, 8'h00, 1'b0, 1'b0);
    do_op("gated", 2'd1, 3'd1, 8'h55, 1'b0, 1'b1);
    do_op("hold0", 2'd0, 3'd0, 8'h55, 1'b0, 1'b0);
    do_op("hold7", 2'd0, 3'd7, 8'h55, 1'b1, 1'b0);
    set_read("sel3", 2'd3, 1'b0);
    do_op("wsel3", 2'd3, 3'd1, 8'h55, 1'b0, 1'b0);

    set_read("oe_off3", 2'd3, 1'b1);
    set_read("oe_off0", 2'd0, 1'b1);
    set_read("oe_off2", 2'd2, 1'b1);

    for (int i = 0; i < 60; i++) begin
      RSEL = 2'($urandom_range(0, 3));
      OE_n = ($urandom_range(0, 4) == 0);
      do_op("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
